// File: rtl/m6502_dma_arbiter.sv
// Bus arbiter and block-copy DMA engine for the m6502 system bus: stalls the
// CPU via rdy, copies len bytes from src to dst, then releases the bus and raises irq.
module m6502_dma_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_datao,
  input  logic              cpu_we_n,
  output logic              cpu_rdy,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_datao,
  output logic              bus_we_n,
  input  logic [7:0]        bus_datai,
  output logic              busy,
  output logic              done,
  output logic              irq_n,
  input  logic              irq_ack
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    CAP,
    WR,
    REL
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  rem;
  logic [7:0]        dbuf;

  always_ff @(posedge clk) begin
    if (res) begin
      state <= IDLE;
      src   <= '0;
      dst   <= '0;
      rem   <= '0;
      dbuf  <= '0;
      irq_n <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            src <= src_addr;
            dst <= dst_addr;
            rem <= len;
          end
        end
        CAP: dbuf <= bus_datai;
        WR: begin
          src <= src + ADDR_W'(1);
          dst <= dst + ADDR_W'(1);
          rem <= rem - LEN_W'(1);
        end
        default: ;
      endcase
      // Setting in REL takes priority over a coincident acknowledge.
      if (state == REL) begin
        irq_n <= 1'b0;
      end else if (irq_ack) begin
        irq_n <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (len == '0) ? REL : REQ;
        end
      end
      // An NMOS 6502 ignores rdy during writes, so wait for a read cycle.
      REQ: begin
        if (cpu_we_n) begin
          state_nxt = RD;
        end
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = WR;
      WR:      state_nxt = (rem == LEN_W'(1)) ? REL : RD;
      REL:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy   = 1'b1;
    busy      = (state != IDLE);
    done      = (state == REL);
    bus_addr  = cpu_addr;
    bus_datao = cpu_datao;
    bus_we_n  = cpu_we_n;
    case (state)
      REQ: cpu_rdy = 1'b0;
      RD, CAP: begin
        cpu_rdy   = 1'b0;
        bus_addr  = src;
        bus_datao = dbuf;
        bus_we_n  = 1'b1;
      end
      WR: begin
        cpu_rdy   = 1'b0;
        bus_addr  = dst;
        bus_datao = dbuf;
        bus_we_n  = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/m6502_dma_arbiter.md
# m6502_dma_arbiter

Bus arbiter and block-copy DMA engine for the m6502 system bus. It sits between the 6502 core and the shared memory bus. It stalls the CPU through `rdy`, takes ownership of the address/data/write-enable lines, and copies a configured number of bytes from a source to a destination address. When the copy finishes it returns the bus to the CPU and raises an interrupt.

## Interface
- `ADDR_W`, 16: bus address width.
- `LEN_W`, 16: transfer length counter width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `res`  in  1  synchronous reset, active-high.
- `start`  in  1  one-cycle pulse; launches a transfer when idle.
- `src_addr`  in  ADDR_W  first source address, sampled on accepted `start`.
- `dst_addr`  in  ADDR_W  first destination address, sampled on accepted `start`.
- `len`  in  LEN_W  byte count, sampled on accepted `start`; 0 = empty transfer.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_datao`  in  8  CPU write data.
- `cpu_we_n`  in  1  CPU write enable (0 = write).
- `cpu_rdy`  out  1  ready to CPU; 0 stalls the core.
- `bus_addr`  out  ADDR_W  muxed bus address.
- `bus_datao`  out  8  muxed bus write data.
- `bus_we_n`  out  1  muxed bus write enable.
- `bus_datai`  in  8  memory read data; valid the cycle after its address is presented.
- `busy`  out  1  high from the cycle after accepted `start` through REL.
- `done`  out  1  one-cycle pulse in REL.
- `irq_n`  out  1  active-low interrupt; set in REL, cleared by `irq_ack`.
- `irq_ack`  in  1  clears `irq_n`.

## Operation
- States: IDLE, REQ, RD, CAP, WR, REL.
- IDLE:
  - On `start`: latch `src_addr`, `dst_addr` and `len` into `src`, `dst` and `rem`.
  - If `len`=0, go to REL; otherwise go to REQ.
  - `start` in any other state is ignored.
- REQ:
  - `cpu_rdy`=0. The bus still passes through to the CPU.
  - The NMOS core ignores `rdy` on write cycles, so REQ waits until `cpu_we_n`=1 in the current cycle, then goes to RD.
  - REQ lasts at least 1 cycle.
- RD: `bus_addr`=`src`, `bus_we_n`=1. Next state CAP.
- CAP: `bus_addr`=`src`, `bus_we_n`=1. Latch `bus_datai` into `dbuf`. Next state WR.
- WR: `bus_addr`=`dst`, `bus_datao`=`dbuf`, `bus_we_n`=0.
  - On exit: `src`+1 and `dst`+1, both modulo 2^ADDR_W (0xFFFF wraps to 0x0000); `rem`-1.
  - If `rem`=1 before the decrement, go to REL; else go to RD.
- REL: `cpu_rdy`=1, bus returned to the CPU, `done`=1, `irq_n` set low. Next state IDLE.
- Bus mux:
  - In IDLE, REQ and REL, `bus_*` = `cpu_*` combinationally.
  - In RD, CAP and WR, `bus_*` are driven by the engine.
  - `bus_datao` is don't-care on engine read cycles.
- `cpu_rdy`=0 exactly in REQ, RD, CAP and WR.
- irq priority: if `irq_ack` and REL happen in the same cycle, the set wins and `irq_n` stays 0.
- Overlapping regions: copied byte by byte in ascending order; no overlap handling.

## Timing
- Reset values (next edge after `res`=1):
  - state IDLE, `cpu_rdy`=1, `busy`=0, `done`=0, `irq_n`=1, `bus_we_n`=`cpu_we_n` (passthrough).
  - Internal `src`, `dst`, `rem` and `dbuf` are cleared to 0.
- Reset in mid-transfer aborts immediately. No `done` pulse and no irq are produced. Bytes already written stay written.
- Latency for `start` accepted at edge E0, with the CPU reading:
  - REQ during cycle 1, first RD during cycle 2.
  - Byte k (0-based) is written during cycle 4+3k.
  - REL during cycle 2+3N; `cpu_rdy` high again in that cycle.
  - Total: N bytes take 3N+2 cycles minimum, plus 1 per extra REQ cycle spent waiting on a CPU write.
- `len`=0: REL in cycle 1, `done` pulse in cycle 1, `cpu_rdy` never drops.
- `done` lasts exactly one cycle. `busy` falls on the edge leaving REL.
- State outputs (`cpu_rdy`, `busy`, `done`, bus mux select) are decoded from the registered state. `irq_n` is a register.

## Test plan
- Reset, then `start` with `src`=0x8000, `dst`=0x0000, `len`=4, memory 0x8000..0x8003 = 11,22,33,44, CPU reading -> 0x0000..0x0003 = 11,22,33,44; `cpu_rdy` low cycles 1-13; `done` pulses in cycle 14; `irq_n` low from cycle 15.
- `start` while the CPU issues writes in cycles 1-2 -> REQ holds 3 cycles; no engine bus cycle overlaps a CPU write; the CPU write data lands in memory.
- `src`=0xFFFE, `dst`=0x1000, `len`=3 -> reads 0xFFFE, 0xFFFF, 0x0000; writes 0x1000-0x1002.
- `len`=0 -> `done` in cycle 1, `cpu_rdy` stays 1, no engine bus cycles, `irq_n` low.
- `res` asserted in the WR of byte 2 of 5 -> next cycle IDLE, `cpu_rdy`=1, `irq_n`=1, no `done`; only bytes 0-2 written.
- `start` pulsed while busy -> ignored; `irq_ack` coincident with REL -> `irq_n`=0; a later `irq_ack` -> `irq_n`=1.
